// File: rtl/counter_bank_pkg.sv
// Shared definitions for the counter bank: direction encodings and
// width helpers used by the bank and its channels.
package counter_bank_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bits needed to index n items, never less than one.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int k = 1; k < 32; k++) begin
            if ((1 << w) < n) begin
                w = k + 1;
            end
        end
        return w;
    endfunction

    // Largest count value a channel may hold.
    function automatic int count_limit(input int modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One up/down counter, modulo Modulus, wrapping or saturating at the
// limits, with a registered terminal-count flag.
module counter_channel
    import counter_bank_pkg::*;
#(
    parameter int Size     = 5,
    parameter int Modulus  = 2 ** Size,
    parameter bit Saturate = 1'b0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            direction,
    input  logic            load,
    input  logic [Size-1:0] load_value,
    output logic [Size-1:0] count,
    output logic            terminal
);

    localparam logic [Size-1:0] MAX = Size'(count_limit(Modulus));

    logic [Size-1:0] r_count;
    logic            r_term;
    logic [Size-1:0] w_next;
    logic            w_term;

    // Next count: load beats enable; the boundary is tested before
    // stepping so the Size-bit arithmetic never overflows.
    always_comb begin
        w_next = r_count;
        w_term = 1'b0;
        if (load) begin
            w_next = load_value;
        end else if (enable) begin
            if (direction == DIR_UP) begin
                if (r_count == MAX) begin
                    w_term = 1'b1;
                    w_next = Saturate ? r_count : '0;
                end else begin
                    w_next = r_count + Size'(1);
                end
            end else begin
                if (r_count == '0) begin
                    w_term = 1'b1;
                    w_next = Saturate ? r_count : MAX;
                end else begin
                    w_next = r_count - Size'(1);
                end
            end
        end
    end

    // Count and terminal registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_term  <= 1'b0;
        end else begin
            r_count <= w_next;
            r_term  <= w_term;
        end
    end

    assign count    = r_count;
    assign terminal = r_term;

endmodule

// File: rtl/counter_bank.sv
// Bank of independent counter channels sharing one load port; holds
// only the load decode, load clamp and the any_terminal reduction.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int Size     = 5,
    parameter int Channels = 4,
    parameter int Modulus  = 2 ** Size,
    parameter bit Saturate = 1'b0,
    localparam int SelW    = clog2(Channels)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [Channels-1:0]      enable,
    input  logic [Channels-1:0]      direction,
    input  logic                     load,
    input  logic [SelW-1:0]          load_sel,
    input  logic [Size-1:0]          load_value,
    output logic [Channels*Size-1:0] count,
    output logic [Channels-1:0]      terminal,
    output logic                     any_terminal
);

    localparam logic [Size-1:0] MAX = Size'(count_limit(Modulus));

    if (Modulus < 2 || Modulus > (1 << Size)) begin : g_bad_modulus
        $fatal(1, "counter_bank: Modulus must lie in 2..2**Size");
    end

    if (Channels < 1) begin : g_bad_channels
        $fatal(1, "counter_bank: Channels must be at least 1");
    end

    logic [Size-1:0]     w_load_value;
    logic [Channels-1:0] w_load;

    // Loaded values above the top count are pulled down to it.
    assign w_load_value = (load_value > MAX) ? MAX : load_value;

    for (genvar i = 0; i < Channels; i++) begin : g_ch
        // A select past the last channel matches nothing.
        assign w_load[i] = load && (load_sel == SelW'(i));

        counter_channel #(
            .Size     (Size),
            .Modulus  (Modulus),
            .Saturate (Saturate)
        ) u_channel (
            .clock      (clock),
            .reset      (reset),
            .enable     (enable[i]),
            .direction  (direction[i]),
            .load       (w_load[i]),
            .load_value (w_load_value),
            .count      (count[i*Size +: Size]),
            .terminal   (terminal[i])
        );
    end

    assign any_terminal = |terminal;

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench: three builds (wrap x4, saturate x4, wrap x3)
// driven in lockstep and compared with a behavioural model.
module tb_counter_bank;

    localparam int M = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] en;
    logic [3:0] dir;
    logic       ld;
    logic [1:0] ld_sel;
    logic [4:0] lv;

    logic [19:0] cnt0, cnt1;
    logic [14:0] cnt2;
    logic [3:0]  term0, term1;
    logic [2:0]  term2;
    logic        any0, any1, any2;

    logic [4:0] oc [3][4];
    logic       ot [3][4];
    logic [2:0] oany;

    int mc [3][4];
    bit mt [3][4];
    int chans [3] = '{4, 4, 3};
    bit sat   [3] = '{1'b0, 1'b1, 1'b0};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    counter_bank #(.Size(5), .Channels(4), .Modulus(M), .Saturate(1'b0)) dut0 (
        .clock(clk), .reset(rst), .enable(en), .direction(dir),
        .load(ld), .load_sel(ld_sel), .load_value(lv),
        .count(cnt0), .terminal(term0), .any_terminal(any0));

    counter_bank #(.Size(5), .Channels(4), .Modulus(M), .Saturate(1'b1)) dut1 (
        .clock(clk), .reset(rst), .enable(en), .direction(dir),
        .load(ld), .load_sel(ld_sel), .load_value(lv),
        .count(cnt1), .terminal(term1), .any_terminal(any1));

    counter_bank #(.Size(5), .Channels(3), .Modulus(M), .Saturate(1'b0)) dut2 (
        .clock(clk), .reset(rst), .enable(en[2:0]), .direction(dir[2:0]),
        .load(ld), .load_sel(ld_sel), .load_value(lv),
        .count(cnt2), .terminal(term2), .any_terminal(any2));

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            oc[0][c] = cnt0[c*5 +: 5];
            oc[1][c] = cnt1[c*5 +: 5];
            ot[0][c] = term0[c];
            ot[1][c] = term1[c];
            oc[2][c] = '0;
            ot[2][c] = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            oc[2][c] = cnt2[c*5 +: 5];
            ot[2][c] = term2[c];
        end
        oany = {any2, any1, any0};
    end

    // Reference behaviour for one clock edge, from the counting rules.
    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < chans[d]; c++) begin
                if (rst) begin
                    mc[d][c] = 0;
                    mt[d][c] = 0;
                end else if (ld && int'(ld_sel) == c) begin
                    mc[d][c] = (int'(lv) > M - 1) ? M - 1 : int'(lv);
                    mt[d][c] = 0;
                end else if (en[c]) begin
                    if (dir[c]) begin
                        mt[d][c] = (mc[d][c] == M - 1);
                        if (!mt[d][c]) mc[d][c] = mc[d][c] + 1;
                        else if (!sat[d]) mc[d][c] = 0;
                    end else begin
                        mt[d][c] = (mc[d][c] == 0);
                        if (!mt[d][c]) mc[d][c] = mc[d][c] - 1;
                        else if (!sat[d]) mc[d][c] = M - 1;
                    end
                end else begin
                    mt[d][c] = 0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic bit model_any(input int d);
        bit a = 0;
        for (int c = 0; c < chans[d]; c++) a |= mt[d][c];
        return a;
    endfunction

    task automatic idle_inputs();
        rst = 0; en = 0; dir = 0; ld = 0; ld_sel = 0; lv = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        cycle();
        rst = 0;
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < chans[d]; c++) begin
                checks++;
                if (oc[d][c] !== 5'd0 || ot[d][c] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset d%0d c%0d: count=%0d term=%b want 0/0",
                             d, c, oc[d][c], ot[d][c]);
                end
            end
            checks++;
            if (oany[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_any d%0d: got %b want 0", d, oany[d]);
            end
        end
    endtask

    task automatic test_count_up();
        idle_inputs();
        en = 4'hF; dir = 4'hF;
        for (int k = 1; k <= 21; k++) begin
            cycle();
            checks++;
            if (oc[0][0] !== 5'(k % M) || ot[0][0] !== (k == M)) begin
                errors++;
                $display("FAIL count_up edge%0d: count=%0d term=%b want %0d/%b",
                         k, oc[0][0], ot[0][0], k % M, k == M);
            end
            for (int d = 0; d < 3; d++) begin
                for (int c = 0; c < chans[d]; c++) begin
                    checks++;
                    if (oc[d][c] !== 5'(mc[d][c]) || ot[d][c] !== mt[d][c]) begin
                        errors++;
                        $display("FAIL count_up_model d%0d c%0d: %0d/%b want %0d/%b",
                                 d, c, oc[d][c], ot[d][c], mc[d][c], mt[d][c]);
                    end
                end
            end
        end
    endtask

    task automatic test_down_from_reset();
        idle_inputs();
        rst = 1;
        cycle();
        rst = 0; en = 4'b0010; dir = 4'b0000;
        cycle();
        checks++;
        if (oc[0][1] !== 5'd19 || ot[0][1] !== 1'b1 || oany[0] !== 1'b1) begin
            errors++;
            $display("FAIL down_first: count=%0d term=%b any=%b want 19/1/1",
                     oc[0][1], ot[0][1], oany[0]);
        end
        checks++;
        if (oc[1][1] !== 5'd0 || ot[1][1] !== 1'b1) begin
            errors++;
            $display("FAIL down_sat_hold: count=%0d term=%b want 0/1",
                     oc[1][1], ot[1][1]);
        end
        cycle();
        checks++;
        if (oc[0][1] !== 5'd18 || ot[0][1] !== 1'b0 || oany[0] !== 1'b0) begin
            errors++;
            $display("FAIL down_second: count=%0d term=%b any=%b want 18/0/0",
                     oc[0][1], ot[0][1], oany[0]);
        end
    endtask

    task automatic test_saturate();
        idle_inputs();
        rst = 1;
        cycle();
        rst = 0; en = 4'hF; dir = 4'hF;
        for (int k = 0; k < 22; k++) cycle();
        checks++;
        if (oc[1][0] !== 5'd19 || ot[1][0] !== 1'b1) begin
            errors++;
            $display("FAIL sat_top: count=%0d term=%b want 19/1", oc[1][0], ot[1][0]);
        end
        dir = 4'h0;
        for (int k = 0; k < 22; k++) cycle();
        checks++;
        if (oc[1][2] !== 5'd0 || ot[1][2] !== 1'b1 || oany[1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_bottom: count=%0d term=%b any=%b want 0/1/1",
                     oc[1][2], ot[1][2], oany[1]);
        end
        en = 4'h0;
        cycle();
        checks++;
        if (oc[1][2] !== 5'd0 || ot[1][2] !== 1'b0 || oany[1] !== 1'b0) begin
            errors++;
            $display("FAIL sat_release: count=%0d term=%b any=%b want 0/0/0",
                     oc[1][2], ot[1][2], oany[1]);
        end
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < chans[d]; c++) begin
                checks++;
                if (oc[d][c] !== 5'(mc[d][c]) || ot[d][c] !== mt[d][c]) begin
                    errors++;
                    $display("FAIL sat_model d%0d c%0d: %0d/%b want %0d/%b",
                             d, c, oc[d][c], ot[d][c], mc[d][c], mt[d][c]);
                end
            end
        end
    endtask

    task automatic test_load();
        idle_inputs();
        en = 4'hF; dir = 4'($urandom); ld = 1; ld_sel = 2; lv = 5'd7;
        cycle();
        checks++;
        if (oc[0][2] !== 5'd7 || ot[0][2] !== 1'b0) begin
            errors++;
            $display("FAIL load7: count=%0d term=%b want 7/0", oc[0][2], ot[0][2]);
        end
        lv = 5'd25;
        cycle();
        checks++;
        if (oc[0][2] !== 5'd19 || oc[1][2] !== 5'd19 || oc[2][2] !== 5'd19) begin
            errors++;
            $display("FAIL load_clamp: counts=%0d,%0d,%0d want 19",
                     oc[0][2], oc[1][2], oc[2][2]);
        end
        ld_sel = 3; lv = 5'd9;
        cycle();
        ld = 0;
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < chans[d]; c++) begin
                checks++;
                if (oc[d][c] !== 5'(mc[d][c]) || ot[d][c] !== mt[d][c]) begin
                    errors++;
                    $display("FAIL load_model d%0d c%0d: %0d/%b want %0d/%b",
                             d, c, oc[d][c], ot[d][c], mc[d][c], mt[d][c]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 31) == 0);
            en = 4'($urandom);
            dir = 4'($urandom);
            ld = ($urandom_range(0, 3) == 0);
            ld_sel = 2'($urandom);
            lv = 5'($urandom);
            cycle();
            for (int d = 0; d < 3; d++) begin
                for (int c = 0; c < chans[d]; c++) begin
                    checks++;
                    if (oc[d][c] !== 5'(mc[d][c]) || ot[d][c] !== mt[d][c]) begin
                        errors++;
                        $display("FAIL random k%0d d%0d c%0d: %0d/%b want %0d/%b",
                                 k, d, c, oc[d][c], ot[d][c], mc[d][c], mt[d][c]);
                    end
                end
                checks++;
                if (oany[d] !== model_any(d)) begin
                    errors++;
                    $display("FAIL random_any k%0d d%0d: %b want %b",
                             k, d, oany[d], model_any(d));
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        int preset [4] = '{5, 19, 0, 12};
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            ld = 1; ld_sel = 2'(c); lv = 5'(preset[c]);
            cycle();
        end
        checks++;
        if (oc[0][0] !== 5'd5 || oc[0][1] !== 5'd19 ||
            oc[0][2] !== 5'd0 || oc[0][3] !== 5'd12) begin
            errors++;
            $display("FAIL preset: %0d,%0d,%0d,%0d want 5,19,0,12",
                     oc[0][0], oc[0][1], oc[0][2], oc[0][3]);
        end
        rst = 1; ld = 1; ld_sel = 1; lv = 5'd3; en = 4'hF; dir = 4'b0101;
        cycle();
        idle_inputs();
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < chans[d]; c++) begin
                checks++;
                if (oc[d][c] !== 5'd0 || ot[d][c] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_mid d%0d c%0d: %0d/%b want 0/0",
                             d, c, oc[d][c], ot[d][c]);
                end
            end
            checks++;
            if (oany[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_any d%0d: %b want 0", d, oany[d]);
            end
        end
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_count_up();
        test_down_from_reset();
        test_saturate();
        test_load();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
